// File: rtl/run_control.sv
// rtl/run_control.sv - button conditioning and IDLE/RUN/STEP sequencer producing the counter ENABLE tick
// Index 0 of the per-button vectors is START_STOP, index 1 is STEP.
module run_control #(
  parameter int PRESCALE        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic START_STOP,
  input  logic STEP,
  output logic ENABLE,
  output logic RUNNING
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_e;

  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enable_q, enable_d;
  logic          running_q, running_d;

  assign raw = {STEP, START_STOP};

  always_comb begin
    sync1_d   = raw;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    press_d   = deb_q & ~deb_dly_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // Accept the new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    enable_d  = 1'b0;
    running_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // START_STOP wins over a simultaneous STEP press.
        if (press_q[0]) begin
          state_d   = S_RUN;
          running_d = 1'b1;
          enable_d  = (PRESCALE == 1);
        end else if (press_q[1]) begin
          state_d  = S_STEP;
          enable_d = 1'b1;
        end
      end
      S_RUN: begin
        if (press_q[0]) begin
          state_d = S_IDLE;
        end else begin
          running_d = 1'b1;
          presc_d   = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
          enable_d  = (presc_d == PRESC_LAST);
        end
      end
      S_STEP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q   <= S_IDLE;
      presc_q   <= '0;
      enable_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      press_q   <= press_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      presc_q   <= presc_d;
      enable_q  <= enable_d;
      running_q <= running_d;
    end
  end

  assign ENABLE  = enable_q;
  assign RUNNING = running_q;

endmodule

// File: tb/tb_run_control.sv
// tb/tb_run_control.sv - directed bench for run_control with PRESCALE=4 and PRESCALE=1 instances
module tb_run_control;

  localparam int P0     = 4;
  localparam int KEEP   = -1;
  localparam int INF    = 1000000;

  logic clk, rst_n, start_stop, step;
  logic en0, run0, en1, run1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_run_from = 0;
  int   m_run_to   = 0;
  int   m_step_at  = -1;

  run_control #(.PRESCALE(P0), .DEBOUNCE_CYCLES(8)) u_dut (
    .CLK(clk), .RSTn(rst_n), .START_STOP(start_stop), .STEP(step),
    .ENABLE(en0), .RUNNING(run0)
  );

  run_control #(.PRESCALE(1), .DEBOUNCE_CYCLES(8)) u_dut_p1 (
    .CLK(clk), .RSTn(rst_n), .START_STOP(start_stop), .STEP(step),
    .ENABLE(en1), .RUNNING(run1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic wait_after(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) start_stop = v;
    else if (which == 1) step = v;
    else begin
      start_stop = v;
      step       = v;
    end
  endtask

  task automatic hold_btn(input int which, input int t0, input int len);
    set_btn(which, 1'b1);
    wait_after(t0 + len - 1);
    set_btn(which, 1'b0);
  endtask

  task automatic check_window(input string tag, input int t0, input int n);
    for (int k = 0; k < n; k++) begin
      int   abs_e;
      logic r, s, e0, e1;
      abs_e = t0 + k;
      wait_after(abs_e);
      r  = (abs_e >= m_run_from) && (abs_e < m_run_to);
      s  = (abs_e == m_step_at);
      e0 = (r && (((abs_e - m_run_from) % P0) == P0 - 1)) || s;
      e1 = r || s;
      check_bit($sformatf("%s_run0@%0d", tag, k), run0, r);
      check_bit($sformatf("%s_en0@%0d", tag, k), en0, e0);
      check_bit($sformatf("%s_run1@%0d", tag, k), run1, r);
      check_bit($sformatf("%s_en1@%0d", tag, k), en1, e1);
    end
  endtask

  task automatic press_check(input string tag, input int which, input int len, input int n,
                             input int from_off, input int to_off, input int step_off);
    int t0;
    @(posedge clk);
    #2;
    t0 = cyc + 1;
    if (from_off != KEEP) m_run_from = t0 + from_off;
    if (to_off != KEEP) m_run_to = t0 + to_off;
    m_step_at = (step_off == KEEP) ? -1 : t0 + step_off;
    fork
      hold_btn(which, t0, len);
      check_window(tag, t0, n);
    join
    wait_after(cyc + 12);
  endtask

  initial begin
    int a;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    step       = 1'b0;
    #5;
    check_bit("rst_async_en0", en0, 1'b0);
    check_bit("rst_async_run0", run0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    check_window("reset", cyc + 1, 20);

    press_check("glitch5", 0, 5, 20, KEEP, KEEP, KEEP);
    press_check("glitch7", 0, 7, 20, KEEP, KEEP, KEEP);
    press_check("start", 0, 20, 28, 11, INF, KEEP);
    press_check("step_run", 1, 12, 28, KEEP, KEEP, KEEP);
    press_check("stop", 0, 20, 28, KEEP, 11, KEEP);
    press_check("restart8", 0, 8, 28, 11, INF, KEEP);
    press_check("stop2", 0, 20, 28, KEEP, 11, KEEP);
    press_check("step_idle", 1, 12, 24, KEEP, KEEP, 11);
    press_check("both", 2, 20, 28, 11, INF, KEEP);

    a = m_run_from + P0 - 1;
    while (a <= cyc) a += P0;
    wait_after(a);
    check_bit("pre_rst_en0", en0, 1'b1);
    check_bit("pre_rst_run0", run0, 1'b1);
    #4;
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_en0", en0, 1'b0);
    check_bit("mid_rst_run0", run0, 1'b0);
    check_bit("mid_rst_en1", en1, 1'b0);
    check_bit("mid_rst_run1", run1, 1'b0);
    #20;
    rst_n      = 1'b1;
    m_run_from = 0;
    m_run_to   = 0;
    m_step_at  = -1;
    check_window("post_rst", cyc + 1, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
